// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter granting NUM_REQ requesters one shared slave bus.
// Ports: clk, rst_n (async active-low); req/req_write/req_addr/req_wdata per-requester
// transaction inputs; gnt/done one-hot owner and completion pulse; rdata last read data;
// bus_address/bus_wdata/bus_read/bus_write/bus_rdata shared slave bus; busy when not idle.
// Optional macro BUS_ARB_STATS_EN adds grant_count, packed saturating 16-bit per-requester counters.
module bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*4-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           rdata,
    output logic [3:0]            bus_address,
    output logic [31:0]           bus_wdata,
    output logic                  bus_read,
    output logic                  bus_write,
    input  logic [31:0]           bus_rdata,
    output logic                  busy
`ifdef BUS_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_count
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] owner_q, last_owner_q, pick;
    logic          write_q, found, last_beat;
    logic [3:0]    addr_q, cnt_q;
    logic [31:0]   wdata_q, rdata_q;
    // Search starts just above the last owner, so the last owner is tried last.
    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        pick  = last_owner_q;
        for (int j = 1; j <= NUM_REQ; j++) begin
            k = (int'(last_owner_q) + j) % NUM_REQ;
            if (!found && req[k]) begin
                found = 1'b1;
                pick  = IW'(k);
            end
        end
    end
    assign last_beat = cnt_q == 4'(WAIT_CYCLES);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = found ? ACCESS : IDLE;
            ACCESS:  state_d = last_beat ? DONE : ACCESS;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IW'(NUM_REQ - 1);
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) begin
                owner_q <= pick;
                write_q <= req_write[pick];
                addr_q  <= req_addr[4*pick +: 4];
                wdata_q <= req_wdata[32*pick +: 32];
                cnt_q   <= '0;
            end
            if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 4'd1;
                if (last_beat && !write_q) rdata_q <= bus_rdata;
            end
            if (state_q == DONE) last_owner_q <= owner_q;
        end
    end
    // Strobes decode straight from the state register so an async reset drops them at once.
    assign gnt         = (state_q != IDLE) ? NUM_REQ'(1) << owner_q : '0;
    assign done        = (state_q == DONE) ? NUM_REQ'(1) << owner_q : '0;
    assign bus_read    = state_q == ACCESS && !write_q;
    assign bus_write   = state_q == ACCESS && write_q;
    assign bus_address = (state_q == ACCESS) ? addr_q : '0;
    assign bus_wdata   = (state_q == ACCESS) ? wdata_q : '0;
    assign busy        = state_q != IDLE;
    assign rdata       = rdata_q;
`ifdef BUS_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_count <= '0;
        else if (state_q == DONE && grant_count[16*owner_q +: 16] != 16'hFFFF)
            grant_count[16*owner_q +: 16] <= grant_count[16*owner_q +: 16] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (NUM_REQ=4, WAIT_CYCLES=1).
module tb_bus_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, req_write, gnt, done, bus_address;
    logic [15:0]  req_addr;
    logic [127:0] req_wdata;
    logic [31:0]  rdata, bus_wdata, bus_rdata;
    logic         bus_read, bus_write, busy;
    int           tests = 0;
    int           fails = 0;
`ifdef BUS_ARB_STATS_EN
    logic [63:0]  grant_count;
`endif
    bus_arbiter #(.NUM_REQ(4), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata), .busy(busy)
`ifdef BUS_ARB_STATS_EN
        , .grant_count(grant_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
`ifdef BUS_ARB_STATS_EN
        #4000000;
`else
        #100000;
`endif
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
    initial begin
        rst_n = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0; bus_rdata = '0;
        tick; tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {bus_read, bus_write, busy}, 0);
        chk("rst_bus", {bus_address, bus_wdata}, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick;
        // single read by requester 2
        req_addr[11:8] = 4'hA; bus_rdata = 32'hDEADBEEF; req = 4'b0100;
        tick;
        chk("rd_c1_gnt", gnt, 4'b0100);
        chk("rd_c1_strobe", {bus_read, bus_write, busy}, 3'b101);
        chk("rd_c1_addr", bus_address, 4'hA);
        tick;
        chk("rd_c2_strobe", {bus_read, bus_write}, 2'b10);
        chk("rd_c2_addr", bus_address, 4'hA);
        chk("rd_c2_done", done, 0);
        tick;
        chk("rd_c3_done", done, 4'b0100);
        chk("rd_c3_rdata", rdata, 32'hDEADBEEF);
        chk("rd_c3_strobe", {bus_read, bus_write, bus_address}, 0);
        req = '0; bus_rdata = 32'h0BADF00D;
        tick;
        chk("rd_c4_idle", {gnt, done, busy}, 0);
        // single write by requester 0; inputs change after grant must not leak
        req_write = 4'b0001; req_addr[3:0] = 4'h3; req_wdata[31:0] = 32'h12345678; req = 4'b0001;
        tick;
        chk("wr_c1_gnt", gnt, 4'b0001);
        chk("wr_c1_strobe", {bus_read, bus_write}, 2'b01);
        chk("wr_c1_bus", {bus_address, bus_wdata}, {4'h3, 32'h12345678});
        req_addr[3:0] = 4'hF; req_wdata[31:0] = '0;
        tick;
        chk("wr_c2_strobe", {bus_read, bus_write}, 2'b01);
        chk("wr_c2_bus", {bus_address, bus_wdata}, {4'h3, 32'h12345678});
        tick;
        chk("wr_c3_done", done, 4'b0001);
        chk("wr_c3_rdata", rdata, 32'hDEADBEEF);
        chk("wr_c3_bus", {bus_write, bus_wdata}, 0);
        req = '0; req_write = '0;
        tick;
        // rotation with all requests held from reset
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1; req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("rot%0d_gnt", k), gnt, 4'b0001 << (k % 4));
            chk($sformatf("rot%0d_nodone", k), done, 0);
            tick; tick;
            chk($sformatf("rot%0d_done", k), done, 4'b0001 << (k % 4));
            tick;
        end
        // last owner loses: 1 then 3 then 1
        req = 4'b1010;
        tick;
        chk("lo_gnt1", gnt, 4'b0010);
        tick; tick; tick; tick;
        chk("lo_gnt3", gnt, 4'b1000);
        tick; tick; tick; tick;
        chk("lo_gnt1b", gnt, 4'b0010);
        tick; tick;
        chk("lo_done1b", done, 4'b0010);
        req = '0;
        tick;
        // reset in the second ACCESS cycle of a read
        req = 4'b0010;
        tick;
        chk("rs_c1_read", bus_read, 1'b1);
        tick;
        chk("rs_c2_read", bus_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rs_async", {bus_read, gnt, busy}, 0);
        chk("rs_rdata", rdata, 0);
        req = 4'b1001;
        tick;
        chk("rs_nodone", done, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("rs_first_gnt", gnt, 4'b0001);
        tick; tick;
        chk("rs_first_done", done, 4'b0001);
        req = '0;
        tick;
`ifdef BUS_ARB_STATS_EN
        rst_n = 1'b0;
        tick;
        chk("st_rst", grant_count, 0);
        rst_n = 1'b1; req = 4'b0010;
        repeat (70000 * 4) tick;
        req = '0;
        tick; tick; tick; tick;
        chk("st_sat", grant_count[31:16], 16'hFFFF);
        chk("st_others", {grant_count[63:32], grant_count[15:0]}, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra bus strobe cycles per access (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester access request; held until matching done.
REQ-006 SHALL have port req_write  input  NUM_REQ  1=write, 0=read, per requester.
REQ-007 SHALL have port req_addr  input  NUM_REQ*4  packed 4-bit addresses, requester i at [4i+3:4i].
REQ-008 SHALL have port req_wdata  input  NUM_REQ*32  packed write data, requester i at [32i+31:32i].
REQ-009 SHALL have port gnt  output  NUM_REQ  one-hot owner of the shared bus, zero when idle.
REQ-010 SHALL have port done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port rdata  output  32  read data, valid in the done cycle, held until next read completes.
REQ-012 SHALL have ports bus_address  output  4, bus_wdata  output  32, bus_read  output  1, bus_write  output  1  shared slave bus drive.
REQ-013 SHALL have port bus_rdata  input  32  slave read data.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCESS, DONE.
REQ-016 IDLE: if any req bit is high, SHALL select the first set bit searching upward from (last_owner+1) mod NUM_REQ, latch its index, write, addr and wdata, set gnt, and go to ACCESS; otherwise stay in IDLE.
REQ-017 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, driving bus_address and bus_wdata from the latched values and exactly one of bus_read or bus_write.
REQ-018 On the last ACCESS cycle of a read, SHALL register bus_rdata into rdata; writes SHALL leave rdata unchanged.
REQ-019 DONE: SHALL pulse done[owner] for one cycle, clear gnt, update last_owner, and return to IDLE.
REQ-020 Latency: req sampled in IDLE at cycle 0 gives bus strobe in cycles 1..1+WAIT_CYCLES and done in cycle 2+WAIT_CYCLES; max throughput is one access per WAIT_CYCLES+3 cycles.
REQ-021 Outside ACCESS, bus_read and bus_write SHALL be 0, and bus_address and bus_wdata SHALL be 0.
REQ-022 Latched transaction fields SHALL NOT follow req_* changes after the grant; deassertion of req by the owner mid-access SHALL NOT abort the access.
REQ-023 New requests arriving during ACCESS or DONE SHALL be evaluated only in the following IDLE cycle.
REQ-024 The requester that last owned the bus SHALL have lowest priority, so no requester is starved while others hold req continuously.

Reset
REQ-025 On rst_n low, state SHALL be IDLE; gnt, done, bus_read, bus_write, busy, bus_address, bus_wdata and rdata SHALL be 0; last_owner SHALL be NUM_REQ-1, so requester 0 is first priority.
REQ-026 Reset asserted mid-ACCESS SHALL drop bus strobes immediately, asynchronously, with no done pulse.

Configuration
REQ-027 With macro BUS_ARB_STATS_EN defined, SHALL add output grant_count  NUM_REQ*16  packed per-requester counters, incremented in the DONE cycle, saturating at 16'hFFFF, and cleared by reset.
REQ-028 Without BUS_ARB_STATS_EN, SHALL omit the grant_count port and its counters; all other behaviour SHALL be identical.

Verification (NUM_REQ=4, WAIT_CYCLES=1)
REQ-029 The bench SHALL check a single read: req[2]=1, addr 4'hA, bus_rdata=32'hDEADBEEF -> gnt=4'b0100 at cycle 1, bus_read high in cycles 1-2 with bus_address=4'hA, done[2] at cycle 3, rdata=32'hDEADBEEF.
REQ-030 The bench SHALL check a single write: req[0] with write=1, addr 4'h3, wdata 32'h12345678 -> bus_write high for 2 cycles with these values, done[0] at cycle 3, rdata unchanged.
REQ-031 The bench SHALL check rotation: all four req held high from reset -> grants in order 0,1,2,3,0, with a done every 4 cycles.
REQ-032 The bench SHALL check that the last owner loses: req[1] and req[3] held, last owner 1 -> next grant goes to 3, then to 1.
REQ-033 The bench SHALL check reset mid-operation: rst_n low in the second ACCESS cycle -> bus_read, gnt and busy are 0 immediately, no done pulse, and after release a request on req[0] is granted first.
REQ-034 The bench SHALL check stats with BUS_ARB_STATS_EN: 70000 completed accesses on req[1] -> grant_count[31:16]=16'hFFFF and the other counters are 0.
